// File: rtl/wb_regfile_if.sv
// wb_regfile_if -- writeback and read-port bundle for wb_regfile.
//   wb_enable : writeback request from the writeback select stage
//   wb_rd     : destination register index
//   wb_data   : writeback value
//   wb_stall  : pipeline hold; blocks the write this cycle (not queued)
//   rs1_addr/rs2_addr : read indices
//   rs1_data/rs2_data : combinational read values
// master = pipeline side, slave = register file.
interface wb_regfile_if;
  logic        wb_enable;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  modport master (
    output wb_enable, wb_rd, wb_data, wb_stall, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data
  );

  modport slave (
    input  wb_enable, wb_rd, wb_data, wb_stall, rs1_addr, rs2_addr,
    output rs1_data, rs2_data
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile -- 31 x 32-bit architectural register file (x1..x31, x0 reads 0)
// with two combinational read ports and commit bookkeeping.
//   clk         : single clock, all state on rising edge
//   rst_n       : synchronous active-low reset
//   bus         : wb_regfile_if.slave (writeback request + two read ports)
//   write_count : committed-write counter, CNT_WIDTH bits, wraps silently
//   last_rd     : index of the most recent committed write
//   last_valid  : set once any write has committed since reset
// Build option: define REGFILE_BYPASS_EN to forward a committing wb_data to
// a read port addressing the same register in the same cycle. Without it the
// read returns the stored (pre-commit) value.
module wb_regfile #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_regfile_if.slave          bus,
  output logic [CNT_WIDTH-1:0] write_count,
  output logic [4:0]           last_rd,
  output logic                 last_valid
);

  localparam int NUM_REGS = 32;
  localparam int XLEN     = 32;

  // A commit needs a live request, no stall, a nonzero target and no reset.
  logic commit;
  assign commit = rst_n & bus.wb_enable & ~bus.wb_stall & (bus.wb_rd != 5'd0);

  // Storage exists for x1..x31 only; x0 is a constant zero slot in the view.
  logic [NUM_REGS-1:1][XLEN-1:0] regs;
  logic [NUM_REGS-1:0][XLEN-1:0] rd_view;
  assign rd_view = {regs, {XLEN{1'b0}}};

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    always_ff @(posedge clk) begin
      if (!rst_n)
        regs[i] <= '0;
      else if (commit && bus.wb_rd == 5'(i))
        regs[i] <= bus.wb_data;
    end
  end

  // Commit bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_count <= '0;
      last_rd     <= 5'd0;
      last_valid  <= 1'b0;
    end else if (commit) begin
      write_count <= write_count + 1'b1;
      last_rd     <= bus.wb_rd;
      last_valid  <= 1'b1;
    end
  end

  // Read ports. commit already excludes index 0, stall and reset, so the
  // forward path can never fire for any of those.
  always_comb begin
    bus.rs1_data = rd_view[bus.rs1_addr];
    bus.rs2_data = rd_view[bus.rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (commit && bus.rs1_addr == bus.wb_rd) bus.rs1_data = bus.wb_data;
    if (commit && bus.rs2_addr == bus.wb_rd) bus.rs2_data = bus.wb_data;
`else
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile -- scoreboard bench for wb_regfile (CNT_WIDTH=4 so the
// counter wrap is reachable). The stimulus process computes the expected
// outputs of each cycle from an array model and queues them; a monitor on
// the falling edge pops and compares against the DUT.
module tb_wb_regfile;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] write_count;
  logic [4:0]    last_rd;
  logic          last_valid;

  wb_regfile_if bus();

  wb_regfile #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .write_count(write_count), .last_rd(last_rd), .last_valid(last_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [CW-1:0] cnt;
    logic [4:0]  lrd;
    logic        lv;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural state only.
  logic [31:0] mem [32];
  int          m_cnt;
  logic [4:0]  m_lrd;
  logic        m_lv;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic logic [31:0] model_rd(logic [4:0] a, bit cm, logic [4:0] rd, logic [31:0] d);
    if (a == 5'd0) return 32'h0;
    if (BYP && cm && a == rd) return d;
    return mem[a];
  endfunction

  task automatic chk(string nm, string f, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
    end
  endtask

  // Monitor: one expectation per driven cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "rs1_data", bus.rs1_data, e.rs1);
      chk(e.nm, "rs2_data", bus.rs2_data, e.rs2);
      chk(e.nm, "write_count", 32'(write_count), 32'(e.cnt));
      chk(e.nm, "last_rd", 32'(last_rd), 32'(e.lrd));
      chk(e.nm, "last_valid", 32'(last_valid), 32'(e.lv));
    end
  end

  // Drive one cycle, queue its expected outputs, advance the model past the edge.
  task automatic step(bit rst, bit en, logic [4:0] rd, logic [31:0] d, bit st,
                      logic [4:0] a1, logic [4:0] a2, string nm);
    exp_t e;
    bit cm;
    rst_n = rst; bus.wb_enable = en; bus.wb_rd = rd; bus.wb_data = d;
    bus.wb_stall = st; bus.rs1_addr = a1; bus.rs2_addr = a2;
    cm = rst && en && !st && rd != 5'd0;
    e.nm = nm;
    e.rs1 = model_rd(a1, cm, rd, d);
    e.rs2 = model_rd(a2, cm, rd, d);
    e.cnt = CW'(m_cnt);
    e.lrd = m_lrd;
    e.lv  = m_lv;
    q.push_back(e);
    if (!rst) begin
      foreach (mem[i]) mem[i] = 32'h0;
      m_cnt = 0; m_lrd = 5'd0; m_lv = 1'b0;
    end else if (cm) begin
      mem[rd] = d;
      m_cnt = (m_cnt + 1) % (1 << CW);
      m_lrd = rd; m_lv = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.wb_enable = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'h0;
    bus.wb_stall = 1'b0; bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
    foreach (mem[i]) mem[i] = 32'h0;
    m_cnt = 0; m_lrd = 5'd0; m_lv = 1'b0;
    // Unchecked reset edges: storage is unknown before the first one.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Post-reset: every index on both ports reads 0, counters clear.
    for (int i = 0; i < 32; i++) step(1, 0, 5'd0, 32'h0, 0, 5'(i), 5'(31 - i), "reset_read");

    // x5 write then read on both ports.
    step(1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd1, "wr_x5");
    step(1, 0, 5'd0, 32'h0, 0, 5'd5, 5'd5, "rd_x5");

    // Write to x0 is ignored, including same-cycle read of index 0.
    step(1, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 5'd0, "wr_x0");
    step(1, 0, 5'd0, 32'h0, 0, 5'd0, 5'd5, "rd_after_x0");

    // Stalled write is dropped, not queued; unstalled write lands.
    step(1, 1, 5'd7, 32'h12345678, 1, 5'd7, 5'd7, "stall_x7");
    step(1, 0, 5'd0, 32'h0, 0, 5'd7, 5'd7, "rd_x7_stalled");
    step(1, 1, 5'd7, 32'h12345678, 0, 5'd7, 5'd0, "wr_x7");
    step(1, 0, 5'd0, 32'h0, 0, 5'd7, 5'd7, "rd_x7");

    // Same-cycle read of the committing register.
    step(1, 1, 5'd3, 32'hA, 0, 5'd0, 5'd0, "wr_x3_a");
    step(1, 1, 5'd3, 32'hB, 0, 5'd3, 5'd3, "wr_x3_b_fwd");
    step(1, 0, 5'd0, 32'h0, 0, 5'd3, 5'd3, "rd_x3_b");
    // Stalled same-cycle read never forwards.
    step(1, 1, 5'd3, 32'hC, 1, 5'd3, 5'd3, "stall_nofwd");

    // Fill the counter round to exactly a multiple of 16 more commits.
    for (int i = 0; i < 16; i++)
      step(1, 1, 5'(1 + (i % 31)), 32'h100 + 32'(i), 0, 5'(1 + (i % 31)), 5'd9, "wrap");
    step(1, 0, 5'd0, 32'h0, 0, 5'd1, 5'd16, "wrap_chk");

    // Reset beats a same-cycle write to x9.
    step(1, 1, 5'd9, 32'h99, 0, 5'd9, 5'd0, "pre_rst_x9");
    step(0, 1, 5'd9, 32'h77, 0, 5'd9, 5'd9, "rst_vs_wr");
    step(1, 0, 5'd0, 32'h0, 0, 5'd9, 5'd1, "post_rst");
    // First edge after release may commit.
    step(1, 1, 5'd31, 32'h5A5A5A5A, 0, 5'd31, 5'd30, "first_commit");
    step(1, 0, 5'd0, 32'h0, 0, 5'd31, 5'd31, "rd_first");

    // Random traffic with occasional reset, stalls and rd=0.
    for (int i = 0; i < 400; i++) begin
      bit rs = ($urandom_range(0, 49) != 0);
      bit en = ($urandom_range(0, 3) != 0);
      bit st = ($urandom_range(0, 3) == 0);
      logic [4:0] rd = 5'($urandom_range(0, 31));
      logic [4:0] a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      logic [4:0] a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      step(rs, en, rd, $urandom, st, a1, a2, "rand");
    end

    // Drain the scoreboard with a bound.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
